mul32: RTL and testbench

Sequential 32x32 multiplier for the RISC-V M-extension multiply group (MUL, MULH, MULHSU, MULHU). It sits beside `div32` in the execute stage and uses the same hold-valid/ready handshake, so the core drives both units the same way. It computes a full 64-bit product on operand magnitudes with a radix-2 shift-add loop, applies the sign fix, and returns the 32-bit slice the opcode selects.

---
 rtl/mext_pkg.sv | 22 ++
 rtl/neg64.sv | 12 +
 rtl/mul32.sv | 120 ++++++++++++
 tb/tb_mul32.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mext_pkg.sv
// rtl/mext_pkg.sv - shared M-extension constants for mul32/div32 decode
package mext_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam logic [CNT_W-1:0] ITERS = CNT_W'(XLEN);

endpackage

// File: rtl/neg64.sv
// rtl/neg64.sv - conditional two's-complement negate, 64-bit by default
module neg64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/mul32.sv
// rtl/mul32.sv - sequential radix-2 shift-add 32x32 multiplier (MUL/MULH/MULHSU/MULHU)
module mul32
  import mext_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  op_i,
  input  logic        valid_i,
  output logic [31:0] result_o,
  output logic [63:0] product_o,
  output logic        ready_o
);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [63:0]       acc_q, acc_d;
  logic [63:0]       mcand_q, mcand_d;
  logic [31:0]       mplier_q, mplier_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  mul_op_e           op_q, op_d;
  logic [31:0]       result_q, result_d;
  logic [63:0]       product_q, product_d;
  logic              ready_q, ready_d;

  logic              sign_a_in, sign_b_in;
  logic [31:0]       mag_a, mag_b;
  logic [63:0]       fixed;

  assign sign_a_in = a_i[31] & ((op_i == MULH) | (op_i == MULHSU));
  assign sign_b_in = b_i[31] & (op_i == MULH);

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  neg64 #(.W(32)) u_neg_a (.x_i(a_i), .neg_i(sign_a_in), .y_o(mag_a));
  neg64 #(.W(32)) u_neg_b (.x_i(b_i), .neg_i(sign_b_in), .y_o(mag_b));
  neg64 #(.W(64)) u_fix   (.x_i(acc_q), .neg_i(sign_a_q ^ sign_b_q), .y_o(fixed));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      op_q      <= MUL_LO;
      result_q  <= '0;
      product_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      product_q <= product_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    op_d      = op_q;
    result_d  = result_q;
    product_d = product_q;
    ready_d   = ready_q;

    if (!valid_i) begin
      state_d = ST_IDLE;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sign_a_d = sign_a_in;
          sign_b_d = sign_b_in;
          op_d     = mul_op_e'(op_i);
          mcand_d  = {32'b0, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = ST_CALC;
        end
        ST_CALC: begin
          // One extra edge after the last iteration applies the sign fix.
          if (count_q == ITERS) begin
            product_d = fixed;
            result_d  = (op_q == MUL_LO) ? fixed[31:0] : fixed[63:32];
            ready_d   = 1'b1;
            state_d   = ST_DONE;
          end else begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign result_o  = result_q;
  assign product_o = product_q;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_mul32.sv
// tb/tb_mul32.sv - self-checking bench for mul32 against an arithmetic reference model
module tb_mul32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [1:0]  op;
  logic        valid;
  logic [31:0] result;
  logic [63:0] product;
  logic        ready;

  int vectors     = 0;
  int miscompares = 0;

  mul32 dut (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .op_i(op),
    .valid_i(valid), .result_o(result), .product_o(product), .ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: product is the sign/zero-extended operands multiplied mod 2^64.
  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey;
    ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
    ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
    return ex * ey;
  endfunction

  logic        m_busy, m_ready;
  int          m_edges;
  logic [63:0] m_prod, m_pend;
  logic [31:0] m_res;
  logic [1:0]  m_op;

  // A request completes 33 edges after the edge that captured it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_ready = 1'b0; m_edges = 0; m_prod = '0; m_res = '0; m_pend = '0; m_op = 2'b00;
    end else if (!valid) begin
      m_busy = 1'b0; m_ready = 1'b0;
    end else if (!m_busy && !m_ready) begin
      m_busy = 1'b1; m_edges = 0; m_pend = ref_prod(op, a, b); m_op = op;
    end else if (m_busy) begin
      m_edges++;
      if (m_edges == 33) begin
        m_busy  = 1'b0;
        m_ready = 1'b1;
        m_prod  = m_pend;
        m_res   = (m_op == 2'b00) ? m_pend[31:0] : m_pend[63:32];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_vs_model", {63'b0, ready}, {63'b0, m_ready});
      chk("result_vs_model", {32'b0, result}, {32'b0, m_res});
      chk("product_vs_model", product, m_prod);
    end
  end

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp_res, input logic [63:0] exp_prod, input string name);
    int n;
    @(posedge clk); #2;
    a = x; b = y; op = o; valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ready && n < 60);
    chk({name, "_latency"}, 64'(n), 64'd34);
    chk({name, "_result"}, {32'b0, result}, {32'b0, exp_res});
    chk({name, "_product"}, product, exp_prod);
    chk({name, "_model_pin"}, m_prod, exp_prod);
    valid = 1'b0;
    @(posedge clk); #1;
    chk({name, "_release"}, {63'b0, ready}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; a = '0; b = '0; op = 2'b00;
    #12;
    chk("reset_ready", {63'b0, ready}, 64'd0);
    chk("reset_result", {32'b0, result}, 64'd0);
    chk("reset_product", product, 64'd0);
    @(posedge clk); #2; rst = 1'b0;

    run(2'b00, 32'd7, 32'd6, 32'h0000002A, 64'h00000000_0000002A, "mul_7x6");
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 64'h00000000_00000001, "mulh_m1");
    run(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000001, "mulhsu_m1");
    run(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE_00000001, "mulhu_max");
    run(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 64'h40000000_00000000, "mulh_min");
    run(2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 64'hC0000000_80000000, "mulh_minmax");
    run(2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 64'h00000002_FFFFFFFA, "mul_neg");
    run(2'b10, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFA, "mulhsu_neg");

    // Abort mid-CALC, then re-issue on the edge right after the drop.
    @(posedge clk); #2;
    a = 32'h12345678; b = 32'h9ABCDEF0; op = 2'b11; valid = 1'b1;
    repeat (12) @(posedge clk);
    #2; valid = 1'b0;
    run(2'b00, 32'd3, 32'd5, 32'd15, 64'd15, "abort_reissue");

    // Reset during CALC.
    @(posedge clk); #2;
    a = 32'h00012345; b = 32'h00000777; op = 2'b01; valid = 1'b1;
    repeat (15) @(posedge clk);
    #3; rst = 1'b1; valid = 1'b0; #1;
    chk("rst_calc_ready", {63'b0, ready}, 64'd0);
    chk("rst_calc_result", {32'b0, result}, 64'd0);
    chk("rst_calc_product", product, 64'd0);
    @(posedge clk); #2; rst = 1'b0;

    // Reset while holding a result in DONE.
    @(posedge clk); #2;
    a = 32'd7; b = 32'd6; op = 2'b00; valid = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    chk("done_ready", {63'b0, ready}, 64'd1);
    chk("done_result", {32'b0, result}, 64'd42);
    #2; rst = 1'b1; valid = 1'b0; #1;
    chk("rst_done_ready", {63'b0, ready}, 64'd0);
    chk("rst_done_result", {32'b0, result}, 64'd0);
    chk("rst_done_product", product, 64'd0);
    @(posedge clk); #2; rst = 1'b0;

    run(2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 64'h00000001_00000000, "mulhu_after_rst");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
